// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: shares the single regfile write port between the writeback
// stage and one long-latency unit. Writeback has priority; a long-latency result
// that cannot be written immediately waits in a one-entry buffer.
// Optional starvation guard: define RF_ARB_STARVE_GUARD_EN to enable the FORCE
// state and ws_hold. Without it the buffer drains only in writeback-idle cycles.
module rf_wport_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_rf_we,
  input  logic [4:0]  ws_rf_waddr,
  input  logic [31:0] ws_rf_wdata,
  output logic        ws_hold,
  input  logic        lu_req,
  input  logic [4:0]  lu_waddr,
  input  logic [31:0] lu_wdata,
  output logic        lu_ack,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        lu_drop
);

  typedef enum logic [1:0] {
    StIdle,
    StPend,
    StForce
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  buf_waddr_q, buf_waddr_d;
  logic [31:0] buf_wdata_q, buf_wdata_d;

`ifdef RF_ARB_STARVE_GUARD_EN
  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt_q, starve_cnt_d;
`endif

  logic buf_valid;
  logic grant_ws, grant_buf, grant_lu;
  logic hold;
  logic conflict;
  logic capture;

  assign buf_valid = (state_q != StIdle);

  // Port grant: forced drain, then writeback, then buffer, then direct bypass.
  // Everything is gated by resetn so nothing is granted while reset is held.
  always_comb begin
    grant_ws  = 1'b0;
    grant_buf = 1'b0;
    grant_lu  = 1'b0;
    hold      = 1'b0;
    if (resetn) begin
      unique case (state_q)
`ifdef RF_ARB_STARVE_GUARD_EN
        StForce: begin
          hold      = 1'b1;
          grant_buf = 1'b1;
        end
`endif
        StPend: begin
          if (ws_rf_we) grant_ws = 1'b1;
          else          grant_buf = 1'b1;
        end
        default: begin
          if (ws_rf_we)    grant_ws = 1'b1;
          else if (lu_req) grant_lu = 1'b1;
        end
      endcase
    end
  end

  // Writeback to the buffered destination is younger, so the buffered entry dies.
  assign conflict = grant_ws & buf_valid & (ws_rf_waddr == buf_waddr_q);

  // Accept when the buffer is empty or is being written this cycle.
  assign lu_ack  = resetn & lu_req & (~buf_valid | grant_buf);
  assign capture = lu_ack & ~grant_lu;

  // Regfile port mux; with no grant the address/data mirror writeback.
  always_comb begin
    rf_we    = grant_ws | grant_buf | grant_lu;
    rf_waddr = ws_rf_waddr;
    rf_wdata = ws_rf_wdata;
    if (grant_buf) begin
      rf_waddr = buf_waddr_q;
      rf_wdata = buf_wdata_q;
    end else if (grant_lu) begin
      rf_waddr = lu_waddr;
      rf_wdata = lu_wdata;
    end
  end

  assign lu_drop = conflict;

`ifdef RF_ARB_STARVE_GUARD_EN
  assign ws_hold = hold;
`else
  assign ws_hold = 1'b0;
`endif

  // Next-state: capture wins over drain/drop; a blocked full buffer ages.
  always_comb begin
    state_d     = state_q;
    buf_waddr_d = buf_waddr_q;
    buf_wdata_d = buf_wdata_q;
`ifdef RF_ARB_STARVE_GUARD_EN
    starve_cnt_d = starve_cnt_q;
`endif
    if (capture) begin
      state_d     = StPend;
      buf_waddr_d = lu_waddr;
      buf_wdata_d = lu_wdata;
`ifdef RF_ARB_STARVE_GUARD_EN
      starve_cnt_d = '0;
`endif
    end else if (grant_buf || conflict) begin
      state_d = StIdle;
`ifdef RF_ARB_STARVE_GUARD_EN
      starve_cnt_d = '0;
`endif
    end else if ((state_q == StPend) && grant_ws) begin
`ifdef RF_ARB_STARVE_GUARD_EN
      if (starve_cnt_q != StarveMax) starve_cnt_d = starve_cnt_q + 4'd1;
      state_d = (starve_cnt_d == StarveMax) ? StForce : StPend;
`else
      state_d = StPend;
`endif
    end
  end

  // All arbiter state; a buffered entry is lost on reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      buf_waddr_q <= '0;
      buf_wdata_q <= '0;
`ifdef RF_ARB_STARVE_GUARD_EN
      starve_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      buf_waddr_q <= buf_waddr_d;
      buf_wdata_q <= buf_wdata_d;
`ifdef RF_ARB_STARVE_GUARD_EN
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  // A forced drain always empties or refills the buffer with a fresh count.
  a_hold_single : assert property (@(posedge clk) disable iff (!resetn) ws_hold |=> !ws_hold);
  a_ack_drop_excl : assert property (@(posedge clk) disable iff (!resetn) !(lu_ack && lu_drop));

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Bench for rf_wport_arbiter: directed vectors with literal expectations, a
// short random phase, and a transaction-level model of the pending result
// compared against every output on every cycle.
module tb_rf_wport_arbiter;

  localparam int unsigned Limit = 4;
`ifdef RF_ARB_STARVE_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        ws_rf_we;
  logic [4:0]  ws_rf_waddr;
  logic [31:0] ws_rf_wdata;
  logic        ws_hold;
  logic        lu_req;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        lu_ack;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        lu_drop;

  always #5 clk = ~clk;

  rf_wport_arbiter #(.STARVE_LIMIT(Limit)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ws_rf_we   (ws_rf_we),
    .ws_rf_waddr(ws_rf_waddr),
    .ws_rf_wdata(ws_rf_wdata),
    .ws_hold    (ws_hold),
    .lu_req     (lu_req),
    .lu_waddr   (lu_waddr),
    .lu_wdata   (lu_wdata),
    .lu_ack     (lu_ack),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .lu_drop    (lu_drop)
  );

  int total = 0;
  int bad   = 0;

  // Model: the one long-latency result waiting for the port, and how many
  // cycles it has been blocked by writeback.
  bit          m_valid = 1'b0;
  logic [4:0]  m_addr  = '0;
  logic [31:0] m_data  = '0;
  int          m_blocked = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit forced_now();
    return Guard && m_valid && (m_blocked >= int'(Limit));
  endfunction

  task automatic model_compare();
    logic        e_we, e_ack, e_hold, e_drop;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    e_we = 0; e_ack = 0; e_hold = 0; e_drop = 0;
    e_a = ws_rf_waddr;
    e_d = ws_rf_wdata;
    if (resetn) begin
      if (forced_now()) begin
        e_we = 1; e_a = m_addr; e_d = m_data; e_hold = 1; e_ack = lu_req;
      end else if (ws_rf_we) begin
        e_we   = 1;
        e_drop = m_valid && (ws_rf_waddr == m_addr);
        e_ack  = lu_req && !m_valid;
      end else if (m_valid) begin
        e_we = 1; e_a = m_addr; e_d = m_data; e_ack = lu_req;
      end else if (lu_req) begin
        e_we = 1; e_a = lu_waddr; e_d = lu_wdata; e_ack = 1;
      end
    end
    chk("model rf_we", 32'(rf_we), 32'(e_we));
    chk("model rf_waddr", 32'(rf_waddr), 32'(e_a));
    chk("model rf_wdata", rf_wdata, e_d);
    chk("model lu_ack", 32'(lu_ack), 32'(e_ack));
    chk("model ws_hold", 32'(ws_hold), 32'(e_hold));
    chk("model lu_drop", 32'(lu_drop), 32'(e_drop));
  endtask

  task automatic model_update();
    bit written, dropped, bypass, accepted, frc;
    if (!resetn) begin
      m_valid = 0;
      m_blocked = 0;
      return;
    end
    frc      = forced_now();
    written  = frc || (!ws_rf_we && m_valid);
    dropped  = !frc && ws_rf_we && m_valid && (ws_rf_waddr == m_addr);
    bypass   = !m_valid && !ws_rf_we && lu_req;
    accepted = lu_req && (!m_valid || written);
    if (written || dropped) begin
      m_valid = 0;
      m_blocked = 0;
    end else if (m_valid && ws_rf_we && m_blocked < int'(Limit)) begin
      m_blocked++;
    end
    if (accepted && !bypass) begin
      m_valid = 1; m_addr = lu_waddr; m_data = lu_wdata; m_blocked = 0;
    end
  endtask

  // Drive one cycle of inputs, then compare against the model at negedge.
  task automatic cyc(input bit we, input int wa, input int wd,
                     input bit lr, input int la, input int ld);
    ws_rf_we = we; ws_rf_waddr = 5'(wa); ws_rf_wdata = 32'(wd);
    lu_req = lr; lu_waddr = 5'(la); lu_wdata = 32'(ld);
    @(negedge clk);
    model_compare();
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    // Reset: outputs quiet despite requests
    cyc(1, 5, 'h11, 1, 1, 1);
    chk("reset rf_we", 32'(rf_we), 0);
    chk("reset lu_ack", 32'(lu_ack), 0);
    adv();
    cyc(1, 5, 'h11, 1, 1, 1);
    adv();
    resetn = 1'b1;
    cyc(1, 5, 'h11, 0, 0, 0);
    chk("post-reset rf_we", 32'(rf_we), 1);
    chk("post-reset rf_waddr", 32'(rf_waddr), 5);
    chk("post-reset rf_wdata", rf_wdata, 'h11);
    adv();

    // Bypass
    cyc(0, 0, 0, 1, 7, 'hABCD);
    chk("bypass rf_we", 32'(rf_we), 1);
    chk("bypass rf_waddr", 32'(rf_waddr), 7);
    chk("bypass lu_ack", 32'(lu_ack), 1);
    adv();
    cyc(0, 0, 0, 0, 0, 0);
    chk("bypass buffer empty", 32'(rf_we), 0);
    adv();

    // Collision then drain
    cyc(1, 3, 'h33, 1, 9, 'h55);
    chk("collide lu_ack", 32'(lu_ack), 1);
    chk("collide rf_waddr", 32'(rf_waddr), 3);
    adv();
    cyc(0, 0, 0, 0, 0, 0);
    chk("drain rf_waddr", 32'(rf_waddr), 9);
    chk("drain rf_wdata", rf_wdata, 'h55);
    adv();
    cyc(0, 0, 0, 0, 0, 0);
    chk("drain empty", 32'(rf_we), 0);
    adv();

    // Starvation: r10 buffered, writeback busy
    cyc(1, 1, 1, 1, 10, 'hA0);
    adv();
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 10 + i, 10 + i, 0, 0, 0);
      chk("starve ws wins", 32'(rf_waddr), 32'(10 + i));
      adv();
    end
    cyc(1, 15, 15, 0, 0, 0);
    chk("starve c5 ws_hold", 32'(ws_hold), Guard ? 1 : 0);
    chk("starve c5 rf_waddr", 32'(rf_waddr), Guard ? 10 : 15);
    adv();
    cyc(1, 15, 15, 0, 0, 0);
    chk("starve c6 ws_hold", 32'(ws_hold), 0);
    chk("starve c6 rf_waddr", 32'(rf_waddr), 15);
    adv();
    cyc(0, 0, 0, 0, 0, 0);
    chk("starve idle rf_we", 32'(rf_we), Guard ? 0 : 1);
    chk("starve idle rf_waddr", 32'(rf_waddr), Guard ? 0 : 10);
    adv();

    // Conflict drop
    cyc(1, 2, 2, 1, 6, 'h66);
    adv();
    cyc(1, 6, 'h77, 0, 0, 0);
    chk("drop rf_waddr", 32'(rf_waddr), 6);
    chk("drop rf_wdata", rf_wdata, 'h77);
    chk("drop lu_drop", 32'(lu_drop), 1);
    adv();
    cyc(0, 0, 0, 0, 0, 0);
    chk("drop buffer empty", 32'(rf_we), 0);
    adv();

    // Simultaneous drain and capture
    cyc(1, 4, 4, 1, 12, 'hC12);
    adv();
    cyc(0, 0, 0, 1, 13, 'hC13);
    chk("swap rf_waddr", 32'(rf_waddr), 12);
    chk("swap lu_ack", 32'(lu_ack), 1);
    adv();
    cyc(0, 0, 0, 0, 0, 0);
    chk("swap second drain", 32'(rf_waddr), 13);
    adv();

    // Reset with a full buffer loses the entry
    cyc(1, 8, 8, 1, 20, 'h20);
    adv();
    resetn = 1'b0;
    cyc(1, 8, 8, 0, 0, 0);
    chk("midreset rf_we", 32'(rf_we), 0);
    adv();
    resetn = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    chk("midreset lost", 32'(rf_we), 0);
    adv();

    // Random traffic over a small address set to provoke conflicts
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom),
          1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom));
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_wport_arbiter.md
# rf_wport_arbiter

- Shares the single register-file write port between the writeback stage and one long-latency unit (divider/late-load return).
- Writeback has no backpressure, so it normally wins.
- The long-latency result is held in a one-entry buffer until the port is free.
- An optional starvation guard briefly freezes writeback so the buffered result drains.
- Sits between the writeback stage, the long-latency unit and the regfile write port.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive blocked cycles of a full buffer before a forced drain (range 1..15).

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- ws_rf_we  in  1  writeback write request; already qualified by writeback valid
- ws_rf_waddr  in  5  writeback destination
- ws_rf_wdata  in  32  writeback data
- ws_hold  out  1  forces writeback ready_go low this cycle; writeback keeps its request stable
- lu_req  in  1  long-latency unit result valid
- lu_waddr  in  5  long-latency destination
- lu_wdata  in  32  long-latency data
- lu_ack  out  1  result accepted this cycle; unit may drop or replace it next cycle
- rf_we  out  1  regfile write enable
- rf_waddr  out  5  regfile write address
- rf_wdata  out  32  regfile write data
- lu_drop  out  1  one-cycle pulse: buffered entry discarded because of a same-address conflict

## Operation
- State: buf_valid, buf_waddr[4:0], buf_wdata[31:0], starve_cnt[3:0].
- FSM states:
  - IDLE: buf_valid=0.
  - PEND: buf_valid=1, starve_cnt<STARVE_LIMIT.
  - FORCE: buf_valid=1, starve_cnt==STARVE_LIMIT.
- Port grant priority, evaluated each cycle:
  1. FORCE: ws_hold=1; buffer drives rf_*; writeback request ignored. Next state IDLE, or PEND if lu_req is captured the same cycle. starve_cnt←0.
  2. ws_rf_we=1: writeback drives rf_*. In PEND, starve_cnt increments, saturating at STARVE_LIMIT.
  3. PEND and ws_rf_we=0: buffer drives rf_*. buf_valid←0 unless a new lu_req is captured. starve_cnt←0.
  4. IDLE, ws_rf_we=0, lu_req=1: direct bypass. lu_* drives rf_*, lu_ack=1, buffer untouched.
- Buffer capture:
  - lu_ack = lu_req AND (buffer empty OR buffer written this cycle).
  - If granted as bypass (case 4), no capture.
  - Otherwise the accepted request loads buf_* and buf_valid←1.
- Same-address conflict:
  - Condition: buf_valid=1, ws_rf_we=1, ws_hold=0, ws_rf_waddr==buf_waddr.
  - Writeback is younger, so the buffered entry is discarded: buf_valid←0, starve_cnt←0, lu_drop=1.
  - Address 0 is treated like any other; the regfile ignores r0.
- rf_we=0 whenever nothing is granted; rf_waddr/rf_wdata then mirror the writeback inputs.
- No reordering beyond the above. Issue logic guarantees at most one outstanding long-latency result per destination.

## Timing
- rf_*, lu_ack, ws_hold and lu_drop are combinational from the inputs and current state. No added write latency.
- Buffer-to-regfile latency: 1 cycle minimum, STARVE_LIMIT+1 cycles maximum with the guard on.
- ws_hold is asserted for exactly one cycle per forced drain, never two consecutive cycles.
- resetn low: buf_valid=0, starve_cnt=0, state IDLE.
  - While reset is asserted: rf_we=0, lu_ack=0, ws_hold=0, lu_drop=0.
  - A buffered entry at reset is lost.
- Simultaneous drain and capture in the same cycle is legal. The buffer stays full with the new entry and starve_cnt←0.
- starve_cnt counts only cycles where the buffer is full and blocked by writeback.

## Configuration
- RF_ARB_STARVE_GUARD_EN defined: FORCE state and ws_hold are active as described.
- Macro undefined:
  - ws_hold is tied 0, FORCE is unreachable and starve_cnt is removed.
  - The buffer drains only in cycles with ws_rf_we=0; it may wait indefinitely.

## Test plan
- Reset: resetn=0 with ws_rf_we=1 → rf_we=0, lu_ack=0. Release; ws_rf_we=1, waddr=5, wdata=0x11 → rf_we=1, rf_waddr=5, same cycle.
- Bypass: IDLE, ws_rf_we=0, lu_req=1, waddr=7, wdata=0xABCD → same-cycle rf_we=1, rf_waddr=7, lu_ack=1; buffer stays empty.
- Collision then drain: ws_rf_we=1 (r3) with lu_req (r9, 0x55) → lu_ack=1, rf_waddr=3. Next cycle ws_rf_we=0 → rf_waddr=9, rf_wdata=0x55.
- Starvation (guard on, STARVE_LIMIT=4): buffer holds r10; ws_rf_we=1 continuously → ws_hold=1 in the 5th cycle, rf_waddr=10; ws_hold=0 the next cycle, and the held writeback is written then.
- Conflict drop: buffer holds r6, ws_rf_we=1 with waddr=6 → rf_waddr=6 from writeback, lu_drop=1; buffer empty the next cycle.
- Guard off: same stimulus as the starvation test → ws_hold never asserted; buffer drains in the first cycle with ws_rf_we=0.
